hamming_ctrl: RTL and testbench
===============================

# hamming_ctrl

Sequencing controller for the Tang 9k Hamming demonstrator. Synchronises and debounces the four data switches, captures a stable 4-bit word, then runs the Hamming encoder and decoder datapath in order through start/done handshakes. It latches the corrected data and syndrome for the LED and dual seven-segment stages, and flags datapath hangs. Sits between the board inputs and the encode/decode/display logic inside `top`.

## Interface
- `DEBOUNCE_CYCLES`, 270000, consecutive stable cycles before a switch word is accepted (10 ms at 27 MHz).
- `TIMEOUT_CYCLES`, 255, maximum cycles to wait for any `*_done_i`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sw_i`  in  4  raw switches, {dg,cg,bg,ag}, asynchronous to `clk`.
- `enc_start_o`  out  1  one-cycle encoder start pulse.
- `enc_data_o`  out  4  captured word presented to the encoder.
- `enc_done_i`  in  1  encoder finished; codeword valid.
- `dec_start_o`  out  1  one-cycle decoder start pulse.
- `dec_done_i`  in  1  decoder finished; `dec_data_i` and `syndrome_i` valid this cycle.
- `dec_data_i`  in  4  corrected data.
- `syndrome_i`  in  3  error position, 0 = no error.
- `led_o`  out  4  latched corrected data.
- `disp_up_o`  out  4  upper-display nibble: {0, syndrome}.
- `disp_dn_o`  out  4  lower-display nibble: corrected data.
- `busy_o`  out  1  high in every state except IDLE.
- `err_o`  out  1  sticky timeout flag.

## Operation
- Switch path: 2-flop synchroniser, then debounce. The candidate is the synchronised value. The counter increments while the candidate is unchanged, restarts at 0 on any change, and accepts at `DEBOUNCE_CYCLES`. An accepted word that differs from the captured word raises `new_word`.
- FSM states: IDLE, ENCODE, WAIT_ENC, DECODE, WAIT_DEC, UPDATE, FAULT.
- IDLE: on `new_word`, capture into `enc_data_o` -> ENCODE.
- ENCODE: `enc_start_o`=1 for one cycle -> WAIT_ENC.
- WAIT_ENC: on `enc_done_i` -> DECODE.
- DECODE: `dec_start_o`=1 for one cycle -> WAIT_DEC.
- WAIT_DEC: on `dec_done_i`, latch `dec_data_i` and `syndrome_i` -> UPDATE.
- UPDATE: drive the latched values onto `led_o`, `disp_*`; clear `err_o` -> IDLE.
- Timeout: a wait counter clears on entering either WAIT state. When it reaches `TIMEOUT_CYCLES` without done -> FAULT.
- FAULT: set `err_o`; hold display outputs -> IDLE.
- `new_word` is evaluated only in IDLE. Switch changes during a sequence are still debounced and are serviced once the FSM is back in IDLE.
- `*_done_i` is ignored outside the matching WAIT state. Done arriving in the same cycle as the timeout wins; no fault is raised.
- The captured word resets to 0. After reset, nonzero switches start a sequence once debounced.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, captured word 0.
- Reset mid-sequence aborts immediately, with no completion of the handshake.
- Latency from the accept cycle to updated outputs: 1 (IDLE) + 1 (ENCODE) + Le + 1 (DECODE) + Ld + 1 (UPDATE).
  - Le and Ld are the cycles from start to done, with done sampled no earlier than the cycle after start.
- Outputs change only on the clock edge leaving UPDATE. `err_o` sets on the edge leaving FAULT.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Configuration
- `HAMMING_ERR_INJECT_EN`, when defined:
  - adds port `inj_i` (in, 3): single-bit error position, 0 = none.
  - adds port `flip_o` (out, 7): one-hot mask `1 << (inj_i-1)` for positions 1..7, else 0. It is registered in ENCODE and held through WAIT_DEC, so the datapath XORs it onto the codeword.
- When undefined, neither port exists and the datapath never sees an injected error.

## Structure
- `hamming_pkg`: FSM state enum, `SYNC_STAGES`=2, `DATA_W`=4, `SYN_W`=3, `CODE_W`=7.
- Sub-module `sw_debounce`: synchroniser, debounce counter and `new_word` generation, parameterised by `DEBOUNCE_CYCLES`.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4 and `TIMEOUT_CYCLES`=8. Encoder and decoder models return done 2 cycles after start.
- Reset, `sw_i`=0 -> all outputs 0, `busy_o`=0, no start pulses.
- `sw_i`=4'b0001, held stable -> one `enc_start_o`, then one `dec_start_o` with `dec_data_i`=1 and syndrome 0 -> `led_o`=1, `disp_up_o`=0, `disp_dn_o`=1.
- `sw_i` toggles every 2 cycles, then settles at 4'b1011 -> exactly one sequence; `enc_data_o`=4'b1011.
- Encoder model never returns done -> `err_o`=1 after 8 wait cycles; `led_o` keeps its previous value.
  - Next good sequence -> `err_o`=0.
- `sw_i` changes to 4'b1111 during WAIT_DEC -> current sequence completes, then a second sequence runs with `enc_data_o`=4'b1111.
- With `HAMMING_ERR_INJECT_EN` and `inj_i`=5 -> `flip_o`=7'b0010000; decoder model returns syndrome 5 -> `disp_up_o`=5, `led_o` equals the switch word.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and widths for the Hamming demonstrator sequencing controller.
package hamming_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int DATA_W      = 4;
  localparam int SYN_W       = 3;
  localparam int CODE_W      = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENCODE   = 3'd1,
    ST_WAIT_ENC = 3'd2,
    ST_DECODE   = 3'd3,
    ST_WAIT_DEC = 3'd4,
    ST_UPDATE   = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  // One-hot codeword flip mask for error position 1..7; position 0 means no error.
  function automatic logic [CODE_W-1:0] inj_mask(input logic [SYN_W-1:0] pos);
    logic [CODE_W-1:0] m;
    if (pos != 3'd0) begin
      m = CODE_W'(1) << (pos - 3'd1);
    end else begin
      m = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_ctrl_if.sv
// Start/done handshake bundle between the controller and the encode/decode datapath.
interface hamming_ctrl_if;
  import hamming_pkg::*;

  logic              enc_start_o;
  logic [DATA_W-1:0] enc_data_o;
  logic              enc_done_i;
  logic              dec_start_o;
  logic              dec_done_i;
  logic [DATA_W-1:0] dec_data_i;
  logic [SYN_W-1:0]  syndrome_i;

  modport master (
    output enc_start_o, enc_data_o, dec_start_o,
    input  enc_done_i, dec_done_i, dec_data_i, syndrome_i
  );

  modport slave (
    input  enc_start_o, enc_data_o, dec_start_o,
    output enc_done_i, dec_done_i, dec_data_i, syndrome_i
  );
endinterface

// File: rtl/hamming_ctrl_sw_debounce.sv
// Switch synchroniser and debouncer; flags a stable word that differs from the captured one.
module sw_debounce
  import hamming_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_i,
  input  logic [DATA_W-1:0] cur_word_i,
  output logic [DATA_W-1:0] word_o,
  output logic              new_word_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q, sync_d;
  logic [DATA_W-1:0]                  cand_q, cand_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;

  // Synchroniser shift and saturating stability counter.
  always_comb begin
    sync_d = sync_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    sync_d[0] = sw_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    if (sync_q[SYNC_STAGES-1] != cand_q) begin
      cand_d = sync_q[SYNC_STAGES-1];
      cnt_d  = '0;
    end else if (cnt_q != CNT_W'(DEBOUNCE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o     = cand_q;
  assign new_word_o = (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) && (cand_q != cur_word_i);

endmodule

// File: rtl/hamming_ctrl.sv
// Hamming demonstrator sequencer: debounced capture, encode/decode handshakes, display latch.
// Optional error injection ports are enabled by defining HAMMING_ERR_INJECT_EN.
module hamming_ctrl
  import hamming_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_i,
  hamming_ctrl_if.master    dp,
  output logic [DATA_W-1:0] led_o,
  output logic [3:0]        disp_up_o,
  output logic [3:0]        disp_dn_o,
  output logic              busy_o,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [SYN_W-1:0]  inj_i,
  output logic [CODE_W-1:0] flip_o,
`endif
  output logic              err_o
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] enc_data_q, enc_data_d;
  logic [DATA_W-1:0] dec_data_q, dec_data_d;
  logic [SYN_W-1:0]  syn_q, syn_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [3:0]        up_q, up_d, dn_q, dn_d;
  logic              err_q, err_d;
  logic              enc_start_q, enc_start_d, dec_start_q, dec_start_d;
  logic              busy_q, busy_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] word_s;
  logic              new_word_s;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk        (clk),
    .rst        (rst),
    .sw_i       (sw_i),
    .cur_word_i (enc_data_q),
    .word_o     (word_s),
    .new_word_o (new_word_s)
  );

  // Sequencer next state and registered outputs.
  always_comb begin
    state_d    = state_q;
    enc_data_d = enc_data_q;
    dec_data_d = dec_data_q;
    syn_d      = syn_q;
    led_d      = led_q;
    up_d       = up_q;
    dn_d       = dn_q;
    err_d      = err_q;
    wait_d     = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (new_word_s) begin
          enc_data_d = word_s;
          state_d    = ST_ENCODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENCODE: begin
        wait_d  = '0;
        state_d = ST_WAIT_ENC;
      end
      ST_WAIT_ENC: begin
        // Done in the timeout cycle still counts as success.
        if (dp.enc_done_i) begin
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES)) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        wait_d  = '0;
        state_d = ST_WAIT_DEC;
      end
      ST_WAIT_DEC: begin
        if (dp.dec_done_i) begin
          dec_data_d = dp.dec_data_i;
          syn_d      = dp.syndrome_i;
          state_d    = ST_UPDATE;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES)) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_UPDATE: begin
        led_d   = dec_data_q;
        up_d    = {1'b0, syn_q};
        dn_d    = dec_data_q;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    enc_start_d = (state_d == ST_ENCODE);
    dec_start_d = (state_d == ST_DECODE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      enc_data_q  <= '0;
      dec_data_q  <= '0;
      syn_q       <= '0;
      led_q       <= '0;
      up_q        <= '0;
      dn_q        <= '0;
      err_q       <= 1'b0;
      enc_start_q <= 1'b0;
      dec_start_q <= 1'b0;
      busy_q      <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      enc_data_q  <= enc_data_d;
      dec_data_q  <= dec_data_d;
      syn_q       <= syn_d;
      led_q       <= led_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      err_q       <= err_d;
      enc_start_q <= enc_start_d;
      dec_start_q <= dec_start_d;
      busy_q      <= busy_d;
      wait_q      <= wait_d;
    end
  end

`ifdef HAMMING_ERR_INJECT_EN
  logic [CODE_W-1:0] flip_q, flip_d;

  // Flip mask loads in ENCODE and is held until the decode wait ends.
  always_comb begin
    if (state_q == ST_ENCODE) begin
      flip_d = inj_mask(inj_i);
    end else if (state_d == ST_WAIT_ENC || state_d == ST_DECODE || state_d == ST_WAIT_DEC) begin
      flip_d = flip_q;
    end else begin
      flip_d = '0;
    end
  end

  // Flip mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_q <= '0;
    end else begin
      flip_q <= flip_d;
    end
  end

  assign flip_o = flip_q;
`endif

  assign dp.enc_start_o = enc_start_q;
  assign dp.enc_data_o  = enc_data_q;
  assign dp.dec_start_o = dec_start_q;
  assign led_o          = led_q;
  assign disp_up_o      = up_q;
  assign disp_dn_o      = dn_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_hamming_ctrl.sv
// Self-checking bench for hamming_ctrl with small encoder/decoder handshake models.
module tb_hamming_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'd0;
  logic [3:0] led, up, dn;
  logic       busy, err;
`ifdef HAMMING_ERR_INJECT_EN
  logic [2:0] inj = 3'd0;
  logic [6:0] flip;
`endif

  hamming_ctrl_if dp_if ();

  hamming_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_i      (sw),
    .dp        (dp_if),
    .led_o     (led),
    .disp_up_o (up),
    .disp_dn_o (dn),
    .busy_o    (busy),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_i     (inj),
    .flip_o    (flip),
`endif
    .err_o     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] led;
    logic [3:0] up;
    logic [3:0] dn;
    logic       err;
    logic [3:0] enc;
  } exp_t;

  typedef struct {
    logic [3:0] sw;
    logic [2:0] syn;
  } vec_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         enc_starts = 0;
  bit         mon_en = 1'b0;
  bit         enc_hang = 1'b0;
  logic [2:0] syn_tb = 3'd0;
  logic [3:0] m_led = 4'd0, m_up = 4'd0, m_dn = 4'd0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_good(input logic [3:0] w, input logic [2:0] s);
    exp_t e;
    e.led = w; e.up = {1'b0, s}; e.dn = w; e.err = 1'b0; e.enc = w;
    m_led = e.led; m_up = e.up; m_dn = e.dn;
    sb.push_back(e);
  endtask

  task automatic push_fault(input logic [3:0] w);
    exp_t e;
    e.led = m_led; e.up = m_up; e.dn = m_dn; e.err = 1'b1; e.enc = w;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d results outstanding after %0d cycles, expected 0", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic wait_dec_start(input string name);
    int n = 0;
    while (dp_if.dec_start_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (dp_if.dec_start_o !== 1'b1) begin
      bad++;
      $display("FAIL %s: dec_start never seen, expected within 100 cycles", name);
    end
  endtask

  // Encoder model: done two cycles after start unless hung.
  initial begin : enc_model
    int pend = 0;
    dp_if.enc_done_i = 1'b0;
    forever begin
      @(negedge clk);
      dp_if.enc_done_i = 1'b0;
      if (rst) pend = 0;
      else if (dp_if.enc_start_o) pend = 2;
      else if (pend > 0) begin
        pend--;
        if (pend == 0 && !enc_hang) dp_if.enc_done_i = 1'b1;
      end
    end
  end

  // Decoder model: returns the captured word as corrected data with syndrome syn_tb.
  initial begin : dec_model
    int pend = 0;
    dp_if.dec_done_i = 1'b0;
    dp_if.dec_data_i = 4'd0;
    dp_if.syndrome_i = 3'd0;
    forever begin
      @(negedge clk);
      dp_if.dec_done_i = 1'b0;
      if (rst) pend = 0;
      else if (dp_if.dec_start_o) pend = 2;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          dp_if.dec_done_i = 1'b1;
          dp_if.dec_data_i = dp_if.enc_data_o;
          dp_if.syndrome_i = syn_tb;
        end
      end
    end
  end

  // Monitor: a falling busy ends a sequence; compare against the scoreboard head.
  initial begin : monitor
    logic busy_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (dp_if.enc_start_o === 1'b1) enc_starts++;
      if (mon_en && busy_prev && !busy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL seq_unexpected: sequence ended with led=%0h, expected none", led);
        end else begin
          e = sb.pop_front();
          check("led", {4'd0, led}, {4'd0, e.led});
          check("disp_up", {4'd0, up}, {4'd0, e.up});
          check("disp_dn", {4'd0, dn}, {4'd0, e.dn});
          check("err", {7'd0, err}, {7'd0, e.err});
          check("enc_data", {4'd0, dp_if.enc_data_o}, {4'd0, e.enc});
        end
      end
      busy_prev = busy;
    end
  end

  initial begin : main
    vec_t vecs[5];
    int   s0;
    vecs[0] = '{4'b0001, 3'd0};
    vecs[1] = '{4'b1010, 3'd3};
    vecs[2] = '{4'b0110, 3'd7};
    vecs[3] = '{4'b1111, 3'd0};
    vecs[4] = '{4'b0000, 3'd2};

    // Reset state with switches at zero.
    repeat (3) @(negedge clk);
    check("rst_led", {4'd0, led}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_err", {7'd0, err}, 8'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_starts", 8'(enc_starts), 8'd0);
    check("idle_busy", {7'd0, busy}, 8'd0);
    check("idle_up", {4'd0, up}, 8'd0);
    check("idle_enc_data", {4'd0, dp_if.enc_data_o}, 8'd0);

    // Table-driven stable words.
    for (int i = 0; i < 5; i++) begin
      s0 = enc_starts;
      syn_tb = vecs[i].syn;
      sw = vecs[i].sw;
      push_good(vecs[i].sw, vecs[i].syn);
      wait_empty("vec_seq", 200);
      repeat (5) @(negedge clk);
      check("vec_one_start", 8'(enc_starts - s0), 8'd1);
    end

    // Bouncing switches, then settle.
    s0 = enc_starts;
    syn_tb = 3'd0;
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 4'b0110 : 4'b1001;
      repeat (2) @(negedge clk);
    end
    sw = 4'b1011;
    push_good(4'b1011, 3'd0);
    wait_empty("bounce_seq", 200);
    repeat (20) @(negedge clk);
    check("bounce_one_start", 8'(enc_starts - s0), 8'd1);
    check("bounce_enc_data", {4'd0, dp_if.enc_data_o}, 8'b1011);

    // Encoder hang -> fault, outputs held; next good sequence clears err.
    enc_hang = 1'b1;
    sw = 4'b0101;
    push_fault(4'b0101);
    wait_empty("hang_seq", 200);
    check("hang_busy", {7'd0, busy}, 8'd0);
    enc_hang = 1'b0;
    sw = 4'b0110;
    push_good(4'b0110, 3'd0);
    wait_empty("recover_seq", 200);

    // Switch change during WAIT_DEC is serviced after the current sequence.
    s0 = enc_starts;
    sw = 4'b0011;
    push_good(4'b0011, 3'd0);
    wait_dec_start("mid_dec_start");
    sw = 4'b1111;
    push_good(4'b1111, 3'd0);
    wait_empty("mid_seq", 300);
    repeat (5) @(negedge clk);
    check("mid_two_starts", 8'(enc_starts - s0), 8'd2);

`ifdef HAMMING_ERR_INJECT_EN
    // Injected error at position 5.
    inj = 3'd5;
    syn_tb = 3'd5;
    sw = 4'b1001;
    push_good(4'b1001, 3'd5);
    wait_dec_start("inj_dec_start");
    @(negedge clk);
    check("inj_flip", {1'b0, flip}, 8'b0010000);
    wait_empty("inj_seq", 200);
    check("inj_flip_idle", {1'b0, flip}, 8'd0);
    inj = 3'd0;
    syn_tb = 3'd0;
`endif

    // Reset mid-sequence aborts; nonzero switches restart once debounced.
    mon_en = 1'b0;
    sw = 4'b1100;
    s0 = 0;
    while (dp_if.enc_start_o !== 1'b1 && s0 < 100) begin
      @(negedge clk);
      s0++;
    end
    check("rst_mid_start_seen", {7'd0, dp_if.enc_start_o}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {7'd0, busy}, 8'd0);
    check("rst_mid_led", {4'd0, led}, 8'd0);
    check("rst_mid_enc_data", {4'd0, dp_if.enc_data_o}, 8'd0);
    check("rst_mid_err", {7'd0, err}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    push_good(4'b1100, 3'd0);
    wait_empty("post_rst_seq", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
